// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, lane constants
// and port indices.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] BE_WORD   = 4'b1111;
    localparam int         NUM_PORTS = 2;
    localparam logic       PORT0     = 1'b0;
    localparam logic       PORT1     = 1'b1;

    function automatic logic [2:0] lane_count(input logic [3:0] be);
        lane_count = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side req/gnt bus of the data-memory arbiter; master = requester,
// slave = arbiter.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              we;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, wdata, be, we,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, addr, wdata, be, we,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_align_check.sv
// Combinational alignment check of a byte address against its lane enables.
module dmem_align_check
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [3:0] be,
    output logic       misaligned
);
    // Zero or one lane is always legal; three lanes is not a natural access size.
    always_comb begin
        misaligned = 1'b0;
        if (be == BE_WORD)
            misaligned = |addr_lo;
        else if (lane_count(be) == 3'd2)
            misaligned = addr_lo[0];
        else if (lane_count(be) == 3'd3)
            misaligned = 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/gnt arbiter in front of the single-port data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    state_t                                state;
    logic                                  sel_q, mis_q;
    logic [NUM_PORTS-1:0]                  gnt_q, rvalid_q, err_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      rdata_q;

    logic                                  win_sel, w_mis, w_we;
    logic [ADDR_W-1:0]                     w_addr;
    logic [DATA_W-1:0]                     w_wdata;
    logic [3:0]                            w_be;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    // On a conflict the port that did not win last goes next.
    always_comb win_sel = p0.req ? (p1.req ? ~last_q : PORT0) : PORT1;
`else
    always_comb win_sel = p0.req ? PORT0 : PORT1;
`endif

    always_comb begin
        w_addr  = win_sel ? p1.addr  : p0.addr;
        w_wdata = win_sel ? p1.wdata : p0.wdata;
        w_be    = win_sel ? p1.be    : p0.be;
        w_we    = win_sel ? p1.we    : p0.we;
    end

    dmem_align_check u_align (
        .addr_lo    (w_addr[1:0]),
        .be         (w_be),
        .misaligned (w_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= PORT0;
            mis_q     <= 1'b0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= PORT1;
`endif
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            case (state)
                ST_IDLE: if (p0.req || p1.req) begin
                    mem_addr       <= w_addr;
                    mem_wdata      <= w_wdata;
                    mem_be         <= w_be;
                    mem_we         <= w_we & ~w_mis;
                    gnt_q[win_sel] <= 1'b1;
                    sel_q          <= win_sel;
                    mis_q          <= w_mis;
                    busy           <= 1'b1;
                    state          <= ST_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_q         <= win_sel;
`endif
                end
                ST_ACCESS: begin
                    // Read data settled at the falling edge; the write lands on this edge.
                    rvalid_q[sel_q] <= 1'b1;
                    err_q[sel_q]    <= mis_q;
                    rdata_q[sel_q]  <= mis_q ? '0 : mem_rdata;
                    mem_we          <= 1'b0;
                    busy            <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign p0.gnt    = gnt_q[PORT0];
    assign p0.rvalid = rvalid_q[PORT0];
    assign p0.err    = err_q[PORT0];
    assign p0.rdata  = rdata_q[PORT0];
    assign p1.gnt    = gnt_q[PORT1];
    assign p1.rvalid = rvalid_q[PORT1];
    assign p1.err    = err_q[PORT1];
    assign p1.rdata  = rdata_q[PORT1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit FIRST = 1'b1;
`else
    localparam bit FIRST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we, busy;
    int          total = 0, bad = 0, we_hits = 0;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) p0_if ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) p1_if ();

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .p0(p0_if.slave), .p1(p1_if.slave),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            we_hits <= we_hits + 1;
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) mem[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end
    always @(negedge clk) mem_rdata <= mem[mem_addr[9:2]];

    function automatic logic gnt_of(input bit p);    return p ? p1_if.gnt    : p0_if.gnt;    endfunction
    function automatic logic rvalid_of(input bit p); return p ? p1_if.rvalid : p0_if.rvalid; endfunction
    function automatic logic [31:0] rdata_of(input bit p); return p ? p1_if.rdata : p0_if.rdata; endfunction

    task automatic drive(input bit p, input logic r, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic w);
        if (p) begin p1_if.req = r; p1_if.addr = a; p1_if.wdata = d; p1_if.be = b; p1_if.we = w; end
        else   begin p0_if.req = r; p0_if.addr = a; p0_if.wdata = d; p0_if.be = b; p0_if.we = w; end
    endtask

    task automatic drop(input bit p);
        if (p) p1_if.req = 1'b0; else p0_if.req = 1'b0;
    endtask

    // One complete transaction; gc is the negedge index at which gnt was seen (-1 on timeout).
    task automatic access(input bit p, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b,
                          input logic w, output int gc, output logic rv, output logic [31:0] rd,
                          output logic er);
        drive(p, 1'b1, a, d, b, w);
        gc = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (gnt_of(p) === 1'b1) begin gc = c; break; end
        end
        drop(p);
        @(negedge clk);
        rv = rvalid_of(p);
        rd = rdata_of(p);
        er = p ? p1_if.err : p0_if.err;
    endtask

    task automatic test_reset;
        drive(0, 0, '0, '0, '0, 0);
        drive(1, 0, '0, '0, '0, 0);
        repeat (3) @(negedge clk);
        total++; if ({p0_if.gnt, p0_if.rvalid, p0_if.err, p1_if.gnt, p1_if.rvalid, p1_if.err} !== 6'b0) begin
            bad++; $display("FAIL reset_pulses got=%b exp=0", {p0_if.gnt, p0_if.rvalid, p0_if.err, p1_if.gnt, p1_if.rvalid, p1_if.err}); end
        total++; if ({p0_if.rdata, p1_if.rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rdata got=%h exp=0", {p0_if.rdata, p1_if.rdata}); end
        total++; if ({mem_addr, mem_wdata, mem_be, mem_we, busy} !== 48'h0) begin
            bad++; $display("FAIL reset_mem got=%h exp=0", {mem_addr, mem_wdata, mem_be, mem_we, busy}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_p0_rw;
        int gc; logic rv, er; logic [31:0] rd;
        access(0, 10'h010, 32'hDEADBEEF, 4'hF, 1, gc, rv, rd, er);
        total++; if (gc !== 0) begin bad++; $display("FAIL p0_wr_gnt_latency got=%0d exp=0", gc); end
        total++; if ({rv, er} !== 2'b10) begin bad++; $display("FAIL p0_wr_resp got=%b exp=10", {rv, er}); end
        access(0, 10'h010, 32'h0, 4'hF, 0, gc, rv, rd, er);
        total++; if ({gc == 0, rv, er} !== 3'b110) begin bad++; $display("FAIL p0_rd_resp got=%b exp=110", {gc == 0, rv, er}); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL p0_rd_data got=%h exp=deadbeef", rd); end
        @(negedge clk);
        total++; if (p0_if.rvalid !== 1'b0) begin bad++; $display("FAIL p0_rvalid_pulse got=%b exp=0", p0_if.rvalid); end
        total++; if ({p1_if.gnt, p1_if.rvalid, p1_if.err, p1_if.rdata} !== 35'h0) begin
            bad++; $display("FAIL p1_quiet got=%h exp=0", {p1_if.gnt, p1_if.rvalid, p1_if.err, p1_if.rdata}); end
    endtask

    task automatic test_conflict(input int rep);
        bit w, l; logic [31:0] ew, el;
        w = FIRST; l = ~FIRST;
        ew = w ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
        el = w ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
        drive(0, 1, 10'h020, 32'h0, 4'hF, 0);
        drive(1, 1, 10'h024, 32'h0, 4'hF, 0);
        @(negedge clk);
        total++; if ({gnt_of(w), gnt_of(l), busy} !== 3'b101) begin
            bad++; $display("FAIL conflict%0d_first_gnt got=%b exp=101", rep, {gnt_of(w), gnt_of(l), busy}); end
        drop(w);
        @(negedge clk);
        total++; if ({rvalid_of(w), gnt_of(l), busy, rdata_of(w)} !== {3'b100, ew}) begin
            bad++; $display("FAIL conflict%0d_first_resp got=%h exp=%h", rep, {rvalid_of(w), gnt_of(l), busy, rdata_of(w)}, {3'b100, ew}); end
        @(negedge clk);
        total++; if ({gnt_of(l), rvalid_of(w)} !== 2'b10) begin
            bad++; $display("FAIL conflict%0d_second_gnt got=%b exp=10", rep, {gnt_of(l), rvalid_of(w)}); end
        drop(l);
        @(negedge clk);
        total++; if ({rvalid_of(l), rdata_of(l)} !== {1'b1, el}) begin
            bad++; $display("FAIL conflict%0d_second_resp got=%h exp=%h", rep, {rvalid_of(l), rdata_of(l)}, {1'b1, el}); end
    endtask

    task automatic test_misaligned;
        int gc, h0; logic rv, er; logic [31:0] rd;
        h0 = we_hits;
        access(1, 10'h012, 32'h12345678, 4'hF, 1, gc, rv, rd, er);
        total++; if ({gc == 0, rv, er, rd} !== {3'b111, 32'h0}) begin
            bad++; $display("FAIL mis_word_resp got=%h exp=%h", {gc == 0, rv, er, rd}, {3'b111, 32'h0}); end
        total++; if (we_hits !== h0) begin bad++; $display("FAIL mis_word_mem_we got=%0d exp=%0d", we_hits, h0); end
        access(1, 10'h010, 32'h0, 4'hF, 0, gc, rv, rd, er);
        total++; if ({rv, er, rd} !== {2'b10, 32'hDEADBEEF}) begin
            bad++; $display("FAIL mis_followup_read got=%h exp=%h", {rv, er, rd}, {2'b10, 32'hDEADBEEF}); end
    endtask

    task automatic test_byte_lanes;
        int gc; logic rv, er; logic [31:0] rd;
        access(0, 10'h030, 32'h11223344, 4'hF, 1, gc, rv, rd, er);
        access(0, 10'h030, 32'h000000AA, 4'h1, 1, gc, rv, rd, er);
        total++; if ({gc == 0, rv, er} !== 3'b110) begin bad++; $display("FAIL byte_wr_resp got=%b exp=110", {gc == 0, rv, er}); end
        access(0, 10'h030, 32'h0, 4'hF, 0, gc, rv, rd, er);
        total++; if (rd !== 32'h112233AA) begin bad++; $display("FAIL byte_readback got=%h exp=112233aa", rd); end
        access(0, 10'h030, 32'hFFFFFFFF, 4'h0, 1, gc, rv, rd, er);
        total++; if ({rv, er} !== 2'b10) begin bad++; $display("FAIL be0_resp got=%b exp=10", {rv, er}); end
        access(0, 10'h031, 32'h0, 4'h3, 0, gc, rv, rd, er);
        total++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL half_mis got=%h exp=%h", {rv, er, rd}, {2'b11, 32'h0}); end
        access(0, 10'h032, 32'h0, 4'hC, 0, gc, rv, rd, er);
        total++; if ({rv, er, rd} !== {2'b10, 32'h112233AA}) begin
            bad++; $display("FAIL half_ok_after_be0 got=%h exp=%h", {rv, er, rd}, {2'b10, 32'h112233AA}); end
    endtask

    task automatic test_withdraw;
        int hits;
        hits = 0;
        drive(1, 1, 10'h010, 32'h0, 4'hF, 0);
        @(negedge clk);
        total++; if (p1_if.gnt !== 1'b1) begin bad++; $display("FAIL wd_p1_gnt got=%b exp=1", p1_if.gnt); end
        drop(1);
        drive(0, 1, 10'h030, 32'h0, 4'hF, 0);
        @(negedge clk);
        drop(0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (p0_if.gnt !== 1'b0 || p0_if.rvalid !== 1'b0 || busy !== 1'b0) hits++;
        end
        total++; if (hits !== 0) begin bad++; $display("FAIL wd_p0_issued got=%0d exp=0", hits); end
    endtask

    task automatic test_reset_mid;
        int gc; logic rv, er; logic [31:0] rd;
        access(0, 10'h040, 32'h0, 4'hF, 1, gc, rv, rd, er);
        drive(0, 1, 10'h040, 32'h55555555, 4'hF, 1);
        @(negedge clk);
        total++; if ({p0_if.gnt, mem_we, busy} !== 3'b111) begin
            bad++; $display("FAIL rstmid_access got=%b exp=111", {p0_if.gnt, mem_we, busy}); end
        drop(0);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({mem_we, busy} !== 2'b00) begin bad++; $display("FAIL rstmid_async got=%b exp=00", {mem_we, busy}); end
        @(negedge clk);
        total++; if ({p0_if.rvalid, p1_if.rvalid, mem[8'h10]} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL rstmid_abort got=%h exp=0", {p0_if.rvalid, p1_if.rvalid, mem[8'h10]}); end
        rst_n = 1'b1;
        access(0, 10'h040, 32'h0, 4'hF, 0, gc, rv, rd, er);
        total++; if ({gc == 0, rv, er, rd} !== {3'b110, 32'h0}) begin
            bad++; $display("FAIL rstmid_after got=%h exp=%h", {gc == 0, rv, er, rd}, {3'b110, 32'h0}); end
    endtask

    initial begin
        int gc; logic rv, er; logic [31:0] rd;
        test_reset();
        test_p0_rw();
        access(0, 10'h020, 32'hA0A0A0A0, 4'hF, 1, gc, rv, rd, er);
        access(0, 10'h024, 32'hB1B1B1B1, 4'hF, 1, gc, rv, rd, er);
        test_conflict(0);
        test_conflict(1);
        test_misaligned();
        test_byte_lanes();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
